// File: rtl/div_share_pkg.sv
// Shared definitions for the divider-sharing arbiter.
//   state_t   : controller FSM states
//   DIV_WIDTH : default operand / quotient width
//   Q_SAT     : quotient returned for a zero divisor (all ones)
//   onehot2   : converts a requester index into a 2-bit one-hot vector
package div_share_pkg;

    localparam int DIV_WIDTH = 10;

    localparam logic [DIV_WIDTH-1:0] Q_SAT = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RESP
    } state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
// The pointer names the preferred requester; the other one wins only when
// the preferred one is idle. After a transaction completes, the pointer moves
// to the peer of the requester just served, so a waiting peer goes next.
//   clk, rst   : clock, synchronous active-high reset (pointer -> 0)
//   req        : request vector, bit i = requester i
//   advance    : one-cycle pulse when the current transaction completes
//   served     : index of the requester that was just served
//   grant      : one-hot grant (all zero when nothing is requested)
//   grant_idx  : index of the granted requester (valid when any = 1)
//   any        : at least one request is pending
module rr_arbiter2
    import div_share_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       served,
    output logic [1:0] grant,
    output logic       grant_idx,
    output logic       any
);

    logic ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~served;
        end
    end

    assign any       = |req;
    assign grant_idx = req[ptr] ? ptr : ~ptr;
    assign grant     = any ? onehot2(grant_idx) : 2'b00;

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one load-and-start divider between two requesters.
// A granted request is captured, the divider is sequenced with
// ld_a/ld_b then start, and the result is returned to the requester that
// issued it. Zero divisors are answered directly with a saturated quotient
// and the overflow flag, without touching the divider.
//
// Optional build macro DIV_SHARE_TIMEOUT_EN adds a WAIT-state watchdog:
// after TIMEOUT_CYCLES without div_done the transaction is answered with
// q = 0, ov = 1, and timeout_err pulses for one cycle.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid[1:0]      : per-requester request valid (held until accepted)
//   req_a, req_b        : dividends / divisors, slice i for requester i
//   req_ready[1:0]      : one-hot accept pulse
//   rsp_valid[1:0]      : one-hot response valid, held until rsp_ready
//   rsp_q, rsp_ov       : response quotient / overflow (shared)
//   rsp_ready[1:0]      : per-requester response accept
//   div_ld_a, div_ld_b  : divider operand load strobes
//   div_start           : divider start strobe
//   div_a, div_b        : divider operands, stable from LOAD through WAIT
//   div_done            : divider result-valid pulse (only honoured in WAIT)
//   div_q, div_ov       : divider quotient / overflow
//   timeout_err         : watchdog pulse (DIV_SHARE_TIMEOUT_EN builds only)
module div_share_arbiter
    import div_share_pkg::*;
#(
    parameter int WIDTH          = DIV_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic [1:0]         req_ready,
    output logic [1:0]         rsp_valid,
    output logic [WIDTH-1:0]   rsp_q,
    output logic               rsp_ov,
    input  logic [1:0]         rsp_ready,
    output logic               div_ld_a,
    output logic               div_ld_b,
    output logic               div_start,
    output logic [WIDTH-1:0]   div_a,
    output logic [WIDTH-1:0]   div_b,
    input  logic               div_done,
    input  logic [WIDTH-1:0]   div_q,
    input  logic               div_ov
`ifdef DIV_SHARE_TIMEOUT_EN
    ,
    output logic               timeout_err
`endif
);

    state_t           state;
    logic             gnt_idx;     // requester owning the current transaction
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [1:0]       arb_grant;
    logic             arb_idx;
    logic             arb_any;
    logic             rsp_done;
    logic [WIDTH-1:0] cand_a;
    logic [WIDTH-1:0] cand_b;

    // Handshake only counts once rsp_valid is actually visible to the owner;
    // rsp_ready on the other bit never completes a transaction.
    assign rsp_done = (state == RESP) && rsp_valid[gnt_idx] && rsp_ready[gnt_idx];

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (rsp_done),
        .served    (gnt_idx),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Operand slices of whichever requester the arbiter currently favours.
    assign cand_a = arb_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign cand_b = arb_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

`ifdef DIV_SHARE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register here sees the pre-edge value of every other register.
        if (rst) begin
            // NOTE: every register is reset, including the operand copies;
            // there is no memory array here, so the cost is a few flops and
            // reset leaves no stale operands on the divider pins.
            state     <= IDLE;
            gnt_idx   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            req_ready <= 2'b00;
            rsp_valid <= 2'b00;
            rsp_q     <= '0;
            rsp_ov    <= 1'b0;
            div_ld_a  <= 1'b0;
            div_ld_b  <= 1'b0;
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
`ifdef DIV_SHARE_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            // Strobes default low so each one is a single-cycle pulse.
            req_ready <= 2'b00;
            div_ld_a  <= 1'b0;
            div_ld_b  <= 1'b0;
            div_start <= 1'b0;
`ifdef DIV_SHARE_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt_idx   <= arb_idx;
                        req_ready <= arb_grant;
                        a_reg     <= cand_a;
                        b_reg     <= cand_b;
                        if (cand_b == '0) begin
                            rsp_q  <= Q_SAT;
                            rsp_ov <= 1'b1;
                            state  <= RESP;
                        end else begin
                            state  <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    div_a    <= a_reg;
                    div_b    <= b_reg;
                    div_ld_a <= 1'b1;
                    div_ld_b <= 1'b1;
                    state    <= START;
                end

                START: begin
                    div_start <= 1'b1;
`ifdef DIV_SHARE_TIMEOUT_EN
                    wd_cnt    <= '0;
`endif
                    state     <= WAIT;
                end

                WAIT: begin
                    if (div_done) begin
                        rsp_q     <= div_q;
                        rsp_ov    <= div_ov;
                        rsp_valid <= onehot2(gnt_idx);
                        state     <= RESP;
`ifdef DIV_SHARE_TIMEOUT_EN
                    end else if (wd_cnt == WD_LAST) begin
                        rsp_q       <= '0;
                        rsp_ov      <= 1'b1;
                        rsp_valid   <= onehot2(gnt_idx);
                        timeout_err <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end

                RESP: begin
                    // The zero-divisor path enters RESP without rsp_valid set;
                    // it is raised here, one cycle after the grant.
                    if (rsp_done) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end else begin
                        rsp_valid <= onehot2(gnt_idx);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Self-checking bench for div_share_arbiter.
// A behavioural divider stub answers div_start after a programmable number
// of cycles with q = a / b and ov = (q > 31). The reference model tracks the
// round-robin preference as "the peer of whoever was served last" and
// derives every expected response from the request operands.
module tb_div_share_arbiter;

    localparam int W = 10;

    logic           clk;
    logic           rst;
    logic [1:0]     req_valid;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]     req_ready;
    logic [1:0]     rsp_valid;
    logic [W-1:0]   rsp_q;
    logic           rsp_ov;
    logic [1:0]     rsp_ready;
    logic           div_ld_a;
    logic           div_ld_b;
    logic           div_start;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic           div_done;
    logic [W-1:0]   div_q;
    logic           div_ov;
`ifdef DIV_SHARE_TIMEOUT_EN
    logic           timeout_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int           pref;
    logic [W-1:0] a_op [2];
    logic [W-1:0] b_op [2];

    // Divider stub controls / state
    int           div_lat    = 1;
    bit           div_enable = 1'b1;
    int           stub_cnt   = 0;
    logic [W-1:0] stub_a     = '0;
    logic [W-1:0] stub_b     = '1;

    div_share_arbiter #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_q      (rsp_q),
        .rsp_ov     (rsp_ov),
        .rsp_ready  (rsp_ready),
        .div_ld_a   (div_ld_a),
        .div_ld_b   (div_ld_b),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_done   (div_done),
        .div_q      (div_q),
        .div_ov     (div_ov)
`ifdef DIV_SHARE_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider stub: counts div_lat cycles after the start strobe, then pulses
    // done. Outside done, q/ov carry junk so stray sampling shows up.
    initial begin
        div_done = 1'b0;
        div_q    = '0;
        div_ov   = 1'b0;
    end

    always @(negedge clk) begin
        div_done = 1'b0;
        div_q    = W'($urandom);
        div_ov   = 1'($urandom);
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0 && div_enable) begin
                div_done = 1'b1;
                div_q    = (stub_b != 0) ? stub_a / stub_b : '1;
                div_ov   = ((stub_b != 0) ? stub_a / stub_b : '1) > 31;
            end
        end
        if (div_start) begin
            stub_a   = div_a;
            stub_b   = div_b;
            stub_cnt = div_lat;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at %0t, required finish earlier", $time);
        $fatal(1, "bench timeout");
    end

    function automatic logic [1:0] oh(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_op[i] = a;
        b_op[i] = b;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic rand_op(input int i);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = W'($urandom_range(0, 1023));
        b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 63));
        set_op(i, a, b);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        pref = 0;
    endtask

    // One complete transaction from grant to response handshake.
    // keep = 1: the served requester immediately presents a new request.
    task automatic run_txn(input bit keep, input int stall,
                           output int won, output logic [W-1:0] got_q, output logic got_ov);
        int           w;
        int           n;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] eq;
        logic         eov;

        w      = req_valid[pref] ? pref : 1 - pref;
        won    = -1;
        got_q  = '0;
        got_ov = 1'b0;

        n = 0;
        while (req_ready == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (req_ready !== oh(w)) begin
            n_err++;
            $display("FAIL grant: req_ready=%b required=%b", req_ready, oh(w));
            return;
        end
        won = w;
        ea  = a_op[w];
        eb  = b_op[w];
        if (eb == 0) begin
            eq  = '1;
            eov = 1'b1;
        end else begin
            eq  = ea / eb;
            eov = (ea / eb) > 31;
        end
        if (keep) rand_op(w);
        else      req_valid[w] = 1'b0;

        if (eb == 0) begin
            @(negedge clk);
            n_cmp++;
            if ({div_ld_a, div_ld_b, div_start} !== 3'b000 || rsp_valid !== oh(w)
                || rsp_q !== eq || rsp_ov !== eov) begin
                n_err++;
                $display("FAIL zero_div_rsp: strobes=%b rsp_valid=%b q=%h ov=%b required strobes=000 rsp_valid=%b q=%h ov=%b",
                         {div_ld_a, div_ld_b, div_start}, rsp_valid, rsp_q, rsp_ov, oh(w), eq, eov);
            end
        end else begin
            @(negedge clk);
            n_cmp++;
            if ({div_ld_a, div_ld_b, div_start} !== 3'b110 || div_a !== ea || div_b !== eb) begin
                n_err++;
                $display("FAIL load: strobes=%b a=%0d b=%0d required strobes=110 a=%0d b=%0d",
                         {div_ld_a, div_ld_b, div_start}, div_a, div_b, ea, eb);
            end
            @(negedge clk);
            n_cmp++;
            if ({div_ld_a, div_ld_b, div_start} !== 3'b001 || div_a !== ea || div_b !== eb) begin
                n_err++;
                $display("FAIL start: strobes=%b a=%0d b=%0d required strobes=001 a=%0d b=%0d",
                         {div_ld_a, div_ld_b, div_start}, div_a, div_b, ea, eb);
            end
            n = 0;
            while (rsp_valid == 2'b00 && n < 50) begin
                @(negedge clk);
                n++;
            end
            n_cmp++;
            if (rsp_valid !== oh(w) || n != div_lat + 1 || rsp_q !== eq || rsp_ov !== eov) begin
                n_err++;
                $display("FAIL div_rsp: rsp_valid=%b wait=%0d q=%0d ov=%b required rsp_valid=%b wait=%0d q=%0d ov=%b",
                         rsp_valid, n, rsp_q, rsp_ov, oh(w), div_lat + 1, eq, eov);
                if (rsp_valid == 2'b00) return;
            end
        end
        got_q  = rsp_q;
        got_ov = rsp_ov;

        // Back-pressure: only the non-owner's ready bit is raised.
        for (int s = 0; s < stall; s++) begin
            rsp_ready = oh(1 - w);
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== oh(w) || rsp_q !== eq || rsp_ov !== eov || req_ready !== 2'b00) begin
                n_err++;
                $display("FAIL stall: rsp_valid=%b q=%0d ov=%b req_ready=%b required rsp_valid=%b q=%0d ov=%b req_ready=00",
                         rsp_valid, rsp_q, rsp_ov, req_ready, oh(w), eq, eov);
            end
        end

        rsp_ready = oh(w);
        @(negedge clk);
        rsp_ready = 2'b00;
        n_cmp++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL handshake: rsp_valid=%b req_ready=%b required 00/00", rsp_valid, req_ready);
        end
        pref = 1 - w;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_q, rsp_ov, div_ld_a, div_ld_b, div_start, div_a, div_b} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0",
                     {req_ready, rsp_valid, rsp_q, rsp_ov, div_ld_a, div_ld_b, div_start, div_a, div_b});
        end
    endtask

    task automatic test_single();
        int           won;
        logic [W-1:0] q;
        logic         ov;
        do_reset();
        div_lat = 2;
        set_op(0, 10'd32, 10'd16);
        req_valid = 2'b01;
        run_txn(1'b0, 0, won, q, ov);
        n_cmp++;
        if (won !== 0 || q !== 10'd2 || ov !== 1'b0) begin
            n_err++;
            $display("FAIL single: owner=%0d q=%0d ov=%b required owner=0 q=2 ov=0", won, q, ov);
        end
    endtask

    task automatic test_round_robin();
        int           won;
        logic [W-1:0] q;
        logic         ov;
        do_reset();
        div_lat = 3;
        rand_op(0);
        rand_op(1);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            run_txn(1'b1, 0, won, q, ov);
            n_cmp++;
            if (won !== (k % 2)) begin
                n_err++;
                $display("FAIL rr_order[%0d]: owner=%0d required %0d", k, won, k % 2);
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_zero_divisor();
        int           won;
        logic [W-1:0] q;
        logic         ov;
        do_reset();
        set_op(1, 10'd77, 10'd0);
        req_valid = 2'b10;
        run_txn(1'b0, 0, won, q, ov);
        n_cmp++;
        if (won !== 1 || q !== 10'h3FF || ov !== 1'b1) begin
            n_err++;
            $display("FAIL zero_div: owner=%0d q=%h ov=%b required owner=1 q=3ff ov=1", won, q, ov);
        end
    endtask

    task automatic test_backpressure();
        int           won;
        logic [W-1:0] q;
        logic         ov;
        do_reset();
        div_lat = 4;
        set_op(0, 10'd900, 10'd9);
        set_op(1, 10'd50, 10'd5);
        req_valid = 2'b11;
        run_txn(1'b0, 5, won, q, ov);
        run_txn(1'b0, 2, won, q, ov);
        n_cmp++;
        if (won !== 1 || q !== 10'd10) begin
            n_err++;
            $display("FAIL backpressure_next: owner=%0d q=%0d required owner=1 q=10", won, q);
        end
    endtask

    task automatic test_reset_in_wait();
        int           n;
        int           seen;
        int           won;
        logic [W-1:0] q;
        logic         ov;
        do_reset();
        div_lat = 20;
        set_op(0, 10'd500, 10'd7);
        req_valid = 2'b01;
        n = 0;
        while (req_ready == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
        end
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_q, rsp_ov, div_ld_a, div_ld_b, div_start, div_a, div_b} !== '0) begin
            n_err++;
            $display("FAIL reset_in_wait: got %h required 0",
                     {req_ready, rsp_valid, rsp_q, rsp_ov, div_ld_a, div_ld_b, div_start, div_a, div_b});
        end
        rst  = 1'b0;
        pref = 0;
        // The abandoned divide still completes inside this window.
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || req_ready != 2'b00 || {div_ld_a, div_ld_b, div_start} != 3'b000)
                seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL late_done: activity cycles=%0d required 0", seen);
        end
        div_lat = 3;
        set_op(1, 10'd81, 10'd9);
        req_valid = 2'b10;
        run_txn(1'b0, 0, won, q, ov);
        n_cmp++;
        if (won !== 1 || q !== 10'd9) begin
            n_err++;
            $display("FAIL after_reset: owner=%0d q=%0d required owner=1 q=9", won, q);
        end
    endtask

`ifdef DIV_SHARE_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int pulses;
        do_reset();
        div_enable = 1'b0;
        div_lat    = 3;
        set_op(0, 10'd100, 10'd3);
        req_valid = 2'b01;
        n = 0;
        while (req_ready == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
        end
        req_valid = 2'b00;
        n = 0;
        pulses = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (timeout_err !== 1'b1 || n != 10 || rsp_valid !== 2'b01 || rsp_q !== '0 || rsp_ov !== 1'b1) begin
            n_err++;
            $display("FAIL timeout: err=%b cycles=%0d rsp_valid=%b q=%0d ov=%b required err=1 cycles=10 rsp_valid=01 q=0 ov=1",
                     timeout_err, n, rsp_valid, rsp_q, rsp_ov);
        end
        repeat (3) begin
            @(negedge clk);
            if (timeout_err) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL timeout_pulse: extra pulses=%0d required 0", pulses);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready  = 2'b00;
        div_enable = 1'b1;
    endtask
`endif

    task automatic test_random();
        int           won;
        logic [W-1:0] q;
        logic         ov;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            // Idle requesters may raise new requests; waiting ones hold theirs.
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    rand_op(i);
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == 2'b00) begin
                rand_op(t % 2);
                req_valid[t % 2] = 1'b1;
            end
            div_lat = $urandom_range(1, 6);
            run_txn(1'b0, $urandom_range(0, 3), won, q, ov);
        end
        req_valid = 2'b00;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 2'b00;
        pref      = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_divisor();
        test_backpressure();
        test_reset_in_wait();
`ifdef DIV_SHARE_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
